// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 opcodes, NOP encoding, fetch FSM states and PC range helper
package rv32_pkg;
  localparam logic [6:0] RTYPE = 7'b0110011;
  localparam logic [6:0] ITYPE = 7'b0010011;
  localparam logic [6:0] STYPE = 7'b0100011;
  localparam logic [6:0] JTYPE = 7'b1101111;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic {RUN, FAULT} fetch_state_e;
  // Word aligned and inside a memory of depth words.
  function automatic logic pc_fetchable(input logic [31:0] pc, input int unsigned depth);
    return (pc[1:0] == 2'b00) && (pc < 32'(4 * depth));
  endfunction
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: memory, decode handshake, redirect and fault signals of the fetch stage
interface instr_fetch_if #(parameter int ADDR_W = 7);
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0] imem_rdata;
  logic out_valid;
  logic out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic redirect_valid;
  logic [31:0] redirect_pc;
  logic fault;
  logic [31:0] fault_pc;
  modport master (
    output imem_addr, out_valid, out_pc, out_instr, fault, fault_pc,
    input imem_rdata, out_ready, redirect_valid, redirect_pc
  );
  modport slave (
    input imem_addr, out_valid, out_pc, out_instr, fault, fault_pc,
    output imem_rdata, out_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_pipe_reg.sv
// fetch_pipe_reg: single-entry valid/ready pipeline register holding {pc, instr}
module fetch_pipe_reg
  import rv32_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic        ready_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o
);
  logic valid_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  // Flush beats load; an un-reloaded entry retires when the consumer takes it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      pc_q    <= 32'd0;
      instr_q <= NOP_INSTR;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end
  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC generation and fetch stage feeding decode through a valid/ready register
module instr_fetch
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 128,
  parameter int          ADDR_W   = 7
) (
  input logic clk,
  input logic reset,
  instr_fetch_if.master io
);
  fetch_state_e state_q;
  logic [31:0] pc_q;
  logic [31:0] fault_pc_q;
  logic pc_ok;
  logic slot_free;
  logic fetch_en;
  assign pc_ok     = pc_fetchable(pc_q, DEPTH);
  assign slot_free = !io.out_valid || io.out_ready;
  assign fetch_en  = (state_q == RUN) && !io.redirect_valid && pc_ok && slot_free;
  assign io.imem_addr = pc_q[ADDR_W+1:2];
  assign io.fault     = (state_q == FAULT);
  assign io.fault_pc  = fault_pc_q;
  // Redirect outranks fault entry; a bad target is caught next cycle via pc_ok.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      fault_pc_q <= 32'd0;
    end else if (io.redirect_valid) begin
      state_q <= RUN;
      pc_q    <= io.redirect_pc;
    end else if (state_q == RUN && !pc_ok) begin
      state_q    <= FAULT;
      fault_pc_q <= pc_q;
    end else if (fetch_en) begin
      pc_q <= pc_q + 32'd4;
    end
  end
  fetch_pipe_reg u_pipe (
    .clk     (clk),
    .reset   (reset),
    .load_i  (fetch_en),
    .flush_i (io.redirect_valid),
    .ready_i (io.out_ready),
    .pc_i    (pc_q),
    .instr_i (io.imem_rdata),
    .valid_o (io.out_valid),
    .pc_o    (io.out_pc),
    .instr_o (io.out_instr)
  );
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- PC-generation and fetch stage that sits directly upstream of instruction_mem and feeds the decode stage.
- Holds the program counter and drives the word address into instruction memory, whose read is combinational.
- Registers {pc, instruction} into a single-entry fetch/decode pipeline register with a valid/ready handshake.
- Accepts redirects from the branch/jump unit and flags misaligned or out-of-range fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
DEPTH, 128, instruction memory depth in 32-bit words
ADDR_W, 7, word-address width; must equal clog2(DEPTH)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
imem_addr  output  ADDR_W  word address to instruction memory, equal to pc_q[ADDR_W+1:2]
imem_rdata  input  32  instruction word returned combinationally for imem_addr
out_valid  output  1  fetch/decode register holds a valid instruction
out_ready  input  1  decode accepts the entry this cycle
out_pc  output  32  byte PC of the held instruction
out_instr  output  32  held instruction word
redirect_valid  input  1  branch/jump taken; load redirect_pc
redirect_pc  input  32  byte target PC
fault  output  1  fetch halted on a bad PC
fault_pc  output  32  offending PC, valid while fault=1

Behaviour:
- Reset (reset==0 at a rising edge) sets: pc_q=RESET_PC; state=RUN; out_valid=0; out_pc=0; out_instr=32'h0000_0013 (NOP); fault=0; fault_pc=0. Reset applies mid-operation and overrides all other inputs that cycle.
- State machine has two states, RUN and FAULT.
- pc_ok = (pc_q[1:0]==0) && (pc_q < 4*DEPTH).
- slot_free = !out_valid || out_ready.
- RUN, redirect_valid=0, pc_ok=1, slot_free=1, at the clock edge:
  - out_valid=1, out_pc=pc_q, out_instr=imem_rdata;
  - pc_q=pc_q+4.
  - Sustained throughput is one instruction per cycle. Latency from pc_q to out_valid is 1 cycle.
- RUN, slot_free=0: stall. pc_q and the output register hold. imem_addr stays stable.
- RUN, out_ready=1, no new capture possible: out_valid drops to 0.
- RUN, pc_ok=0, no redirect:
  - go to FAULT; fault=1, fault_pc=pc_q;
  - no capture. The existing output entry still follows the handshake and is not dropped.
- redirect_valid=1, in any state, takes priority over capture, stall and fault entry:
  - out_valid=0 next cycle. This flush applies even if out_ready=1 that cycle, so the entry is discarded, not delivered.
  - pc_q=redirect_pc.
  - state=RUN and fault=0.
  - A bad redirect target is detected in the following cycle through pc_ok (redirect, then FAULT one cycle later).
- FAULT:
  - No fetch. pc_q frozen. fault=1.
  - Exit only by redirect_valid or reset.
- Wrap-around: pc_q=4*DEPTH-4 fetches normally. The increment to 4*DEPTH then faults. The PC never wraps silently.
- The output register must not change while out_valid=1 and out_ready=0.

Decomposition:
- rv32_pkg (shared) holds:
  - opcode constants RTYPE=7'b0110011, ITYPE=7'b0010011, STYPE=7'b0100011, JTYPE=7'b1101111;
  - NOP_INSTR=32'h0000_0013;
  - fetch state enum {RUN, FAULT}.
- One sub-module: fetch_pipe_reg. It is the valid/ready register holding {pc, instr}, with load, flush and reset. The same register is reused for decode/execute.

Test Plan:
1. Reset with RESET_PC=0, memory word k = k, out_ready=1 held. Expect out_pc=0,4,8,12 on consecutive cycles with out_instr=0,1,2,3; out_valid=1 from cycle 1.
2. Stall: hold out_ready=0 for 3 cycles while out_pc=8. Expect out_pc=8 and out_instr=2 held and imem_addr=3 stable. On release, the next entries are 12 then 16.
3. Redirect: while out_pc=12 is valid, pulse redirect_valid with redirect_pc=0x40 and out_ready=1. Expect out_valid=0 next cycle, then out_pc=0x40 with out_instr=16.
4. Misaligned redirect to 0x42. Expect fault=1 and fault_pc=0x42 one cycle later, out_valid=0 and no further fetch. A following redirect to 0x10 clears fault and resumes at out_pc=0x10.
5. End of memory with DEPTH=128: run from redirect 0x1F8. Expect entries at 0x1F8 and 0x1FC, then fault=1 with fault_pc=0x200.
6. Reset asserted mid-stream while stalled with out_valid=1. Next cycle out_valid=0, fault=0, out_instr=0x13, pc_q=RESET_PC.
